// File: rtl/alarm_ring_pkg.sv
// Shared constants for the alarm ring controller: state encodings and the
// width of the seconds-remaining counter.
package alarm_ring_pkg;
    localparam int REM_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } state_t;
endpackage

// File: rtl/alarm_ring_ctrl_if.sv
// Bus between the alarm controller and its surroundings: compare match, tick,
// user buttons in; buzzer and status out.
interface alarm_ring_ctrl_if;
    import alarm_ring_pkg::*;

    logic             enable;
    logic             tick_1hz;
    logic             match;
    logic             stop_btn;
    logic             snooze_btn;
    logic             buzzer;
    logic             ringing;
    logic             snoozed;
    logic [REM_W-1:0] remaining;
    logic [2:0]       snooze_cnt;

    modport master (
        output enable, tick_1hz, match, stop_btn, snooze_btn,
        input  buzzer, ringing, snoozed, remaining, snooze_cnt
    );
    modport slave (
        input  enable, tick_1hz, match, stop_btn, snooze_btn,
        output buzzer, ringing, snoozed, remaining, snooze_cnt
    );
endinterface

// File: rtl/alarm_ring_ctrl_sec_countdown.sv
// Loadable seconds down-counter shared by the ring and snooze intervals.
// Load wins over tick; the count never wraps below zero.
module sec_countdown
    import alarm_ring_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [REM_W-1:0] load_val,
    input  logic             tick,
    output logic [REM_W-1:0] count,
    output logic             expire
);
    assign expire = tick & (count == REM_W'(1));

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (tick && count != '0)
            count <= count - REM_W'(1);
    end
endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm annunciator sequencer: ring, snooze, stop and auto-timeout.
// Define ALARM_BEEP_PATTERN_EN for a 1 s on / 1 s off buzzer while ringing.
module alarm_ring_ctrl
    import alarm_ring_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZES = 3
) (
    input  logic               clk,
    input  logic               reset,
    alarm_ring_ctrl_if.slave   bus
);
    if (RING_SECS < 1 || RING_SECS > 511)     begin : g_bad_ring   $error("RING_SECS out of range");   end
    if (SNOOZE_SECS < 1 || SNOOZE_SECS > 511) begin : g_bad_snooze $error("SNOOZE_SECS out of range"); end
    if (MAX_SNOOZES < 0 || MAX_SNOOZES > 7)   begin : g_bad_max    $error("MAX_SNOOZES out of range"); end

    state_t           state, state_n;
    logic [2:0]       snz, snz_n;
    logic             match_d;
    logic             trigger;
    logic             load, cnt_tick, expire;
    logic [REM_W-1:0] load_val, count;

    assign trigger = bus.enable & bus.match & ~match_d;

    sec_countdown u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .tick     (cnt_tick),
        .count    (count),
        .expire   (expire)
    );

    // match_d keeps sampling through reset so a match still high afterwards
    // is seen as already consumed and cannot retrigger.
    always_ff @(posedge clk) match_d <= bus.match;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            snz   <= '0;
        end else begin
            state <= state_n;
            snz   <= snz_n;
        end
    end

    always_comb begin
        state_n  = state;
        snz_n    = snz;
        load     = 1'b0;
        load_val = '0;
        cnt_tick = 1'b0;
        if (!bus.enable) begin
            state_n = ST_IDLE;
            snz_n   = '0;
            load    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state_n  = ST_RINGING;
                        snz_n    = '0;
                        load     = 1'b1;
                        load_val = REM_W'(RING_SECS);
                    end
                end
                ST_RINGING: begin
                    if (bus.stop_btn) begin
                        state_n = ST_IDLE;
                        snz_n   = '0;
                        load    = 1'b1;
                    end else if (bus.snooze_btn) begin
                        // A press at the snooze limit still consumes this cycle.
                        if (snz < 3'(MAX_SNOOZES)) begin
                            state_n  = ST_SNOOZED;
                            snz_n    = snz + 3'd1;
                            load     = 1'b1;
                            load_val = REM_W'(SNOOZE_SECS);
                        end
                    end else if (bus.tick_1hz) begin
                        cnt_tick = 1'b1;
                        if (expire) begin
                            state_n = ST_IDLE;
                            snz_n   = '0;
                            load    = 1'b1;
                        end
                    end
                end
                ST_SNOOZED: begin
                    if (bus.stop_btn) begin
                        state_n = ST_IDLE;
                        snz_n   = '0;
                        load    = 1'b1;
                    end else if (bus.tick_1hz) begin
                        cnt_tick = 1'b1;
                        if (expire) begin
                            state_n  = ST_RINGING;
                            load     = 1'b1;
                            load_val = REM_W'(RING_SECS);
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    snz_n   = '0;
                    load    = 1'b1;
                end
            endcase
        end
    end

    assign bus.ringing    = (state == ST_RINGING);
    assign bus.snoozed    = (state == ST_SNOOZED);
    assign bus.remaining  = count;
    assign bus.snooze_cnt = snz;

`ifdef ALARM_BEEP_PATTERN_EN
    logic phase;

    always_ff @(posedge clk) begin
        if (reset || state_n != ST_RINGING)
            phase <= 1'b0;
        else if (state != ST_RINGING)
            phase <= 1'b1;
        else if (cnt_tick)
            phase <= ~phase;
    end

    assign bus.buzzer = (state == ST_RINGING) & phase;
`else
    assign bus.buzzer = (state == ST_RINGING);
`endif
endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl with RING_SECS=3, SNOOZE_SECS=2, MAX_SNOOZES=1.
module tb_alarm_ring_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    alarm_ring_ctrl_if bus ();

    alarm_ring_ctrl #(
        .RING_SECS   (3),
        .SNOOZE_SECS (2),
        .MAX_SNOOZES (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef ALARM_BEEP_PATTERN_EN
    localparam bit BEEP = 1'b1;
`else
    localparam bit BEEP = 1'b0;
`endif

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.tick_1hz   = 1'b0;
        bus.stop_btn   = 1'b0;
        bus.snooze_btn = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic r, input logic s, input logic b,
                           input int rem, input int cnt);
        chk({tag, ".ringing"},    32'(bus.ringing),    32'(r));
        chk({tag, ".snoozed"},    32'(bus.snoozed),    32'(s));
        chk({tag, ".buzzer"},     32'(bus.buzzer),     32'(b));
        chk({tag, ".remaining"},  32'(bus.remaining),  32'(rem));
        chk({tag, ".snooze_cnt"}, 32'(bus.snooze_cnt), 32'(cnt));
    endtask

    task automatic tick();
        bus.tick_1hz = 1'b1;
        cyc();
    endtask

    initial begin
        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.tick_1hz   = 1'b0;
        bus.match      = 1'b0;
        bus.stop_btn   = 1'b0;
        bus.snooze_btn = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        chk_all("reset", 0, 0, 0, 0, 0);

        // Trigger and timeout, match held through four ticks
        bus.enable = 1'b1;
        bus.match  = 1'b1;
        cyc();
        chk_all("trig", 1, 0, 1, 3, 0);
        tick();
        chk_all("ring_t1", 1, 0, !BEEP, 2, 0);
        tick();
        chk_all("ring_t2", 1, 0, 1, 1, 0);
        tick();
        chk_all("timeout", 0, 0, 0, 0, 0);
        tick();
        chk_all("no_retrig", 0, 0, 0, 0, 0);
        bus.match = 1'b0;
        cyc();

        // Snooze, return to ringing, snooze limit
        bus.match = 1'b1;
        cyc();
        chk_all("trig2", 1, 0, 1, 3, 0);
        bus.snooze_btn = 1'b1;
        cyc();
        chk_all("snooze", 0, 1, 0, 2, 1);
        tick();
        chk_all("snz_t1", 0, 1, 0, 1, 1);
        tick();
        chk_all("snz_end", 1, 0, 1, 3, 1);
        bus.snooze_btn = 1'b1;
        cyc();
        chk_all("snz_limit", 1, 0, 1, 3, 1);

        // Stop beats snooze and tick in the same cycle
        bus.stop_btn   = 1'b1;
        bus.snooze_btn = 1'b1;
        bus.tick_1hz   = 1'b1;
        cyc();
        chk_all("stop_prio", 0, 0, 0, 0, 0);
        bus.match = 1'b0;
        cyc();

        // Disable while snoozed
        bus.match = 1'b1;
        cyc();
        chk("trig3.ringing", 32'(bus.ringing), 32'd1);
        bus.snooze_btn = 1'b1;
        cyc();
        chk_all("snooze3", 0, 1, 0, 2, 1);
        bus.enable = 1'b0;
        cyc();
        chk_all("disable", 0, 0, 0, 0, 0);
        bus.enable = 1'b1;
        cyc();
        chk_all("reenable", 0, 0, 0, 0, 0);
        bus.match = 1'b0;
        cyc();

        // Reset while ringing with match still high
        bus.match = 1'b1;
        cyc();
        chk_all("trig4", 1, 0, 1, 3, 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_all("mid_reset", 0, 0, 0, 0, 0);
        cyc();
        chk_all("post_reset", 0, 0, 0, 0, 0);
        bus.match = 1'b0;
        cyc();
        chk("match_low.ringing", 32'(bus.ringing), 32'd0);
        bus.match = 1'b1;
        cyc();
        chk_all("retrig", 1, 0, 1, 3, 0);
        bus.stop_btn = 1'b1;
        cyc();
        chk_all("final_stop", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
